// File: rtl/ucmp8_tree.sv
// Unsigned magnitude comparator built as a log-depth tree of compare cells.
// Combinational lt/eq/gt feed same-cycle consumers; a registered copy
// (lt_q/eq_q/gt_q) serves pipelined consumers and is cleared by reset.
module ucmp8_tree #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             lt_q,
    output logic             eq_q,
    output logic             gt_q
);

    // Tree is built over a power-of-two number of leaves; bits at or above
    // NBITS are padding and behave as equal zero MSBs (g=l=0).
    localparam int LOG = (NBITS > 1) ? $clog2(NBITS) : 0;
    localparam int P   = 1 << LOG;

    genvar lvl, k;
    generate
        for (lvl = 0; lvl <= LOG; lvl++) begin : g_lvl
            localparam int N = P >> lvl;
            logic [N-1:0] g;
            logic [N-1:0] l;
            for (k = 0; k < N; k++) begin : g_node
                if (lvl == 0) begin : g_leaf
                    if (k < NBITS) begin : g_real
                        assign g[k] = in0[k] & ~in1[k];
                        assign l[k] = ~in0[k] & in1[k];
                    end else begin : g_pad
                        assign g[k] = 1'b0;
                        assign l[k] = 1'b0;
                    end
                end else begin : g_merge
                    // Higher-order child decides unless it reports equal.
                    assign g[k] = g_lvl[lvl-1].g[2*k+1]
                                | (~g_lvl[lvl-1].l[2*k+1] & g_lvl[lvl-1].g[2*k]);
                    assign l[k] = g_lvl[lvl-1].l[2*k+1]
                                | (~g_lvl[lvl-1].g[2*k+1] & g_lvl[lvl-1].l[2*k]);
                end
            end
        end
    endgenerate

    assign gt = g_lvl[LOG].g[0];
    assign lt = g_lvl[LOG].l[0];
    assign eq = ~(g_lvl[LOG].g[0] | g_lvl[LOG].l[0]);

    // Registered copy of the flags; asynchronous reset clears all three.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
        end else begin
            lt_q <= lt;
            eq_q <= eq;
            gt_q <= gt;
        end
    end

endmodule

// File: tb/tb_ucmp8_tree.sv
// Directed and random checks of the unsigned comparator tree and its
// registered flag copy.
module tb_ucmp8_tree;

    logic       clk;
    logic       reset;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       lt, eq, gt;
    logic       lt_q, eq_q, gt_q;

    int total = 0;
    int bad   = 0;

    ucmp8_tree #(.NBITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .in1   (in1),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt),
        .lt_q  (lt_q),
        .eq_q  (eq_q),
        .gt_q  (gt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Directed vectors; expected flags packed as {lt,eq,gt}.
    localparam int NV = 15;
    logic [7:0] va [NV] = '{8'd0, 8'd127, 8'd150, 8'd254,
                            8'd0, 8'd16, 8'd128, 8'd255,
                            8'd1, 8'd128, 8'd200, 8'd255,
                            8'd255, 8'd0, 8'd128};
    logic [7:0] vb [NV] = '{8'd1, 8'd128, 8'd200, 8'd255,
                            8'd0, 8'd16, 8'd128, 8'd255,
                            8'd0, 8'd127, 8'd150, 8'd254,
                            8'd0, 8'd255, 8'd127};
    logic [2:0] ve [NV] = '{3'b100, 3'b100, 3'b100, 3'b100,
                            3'b010, 3'b010, 3'b010, 3'b010,
                            3'b001, 3'b001, 3'b001, 3'b001,
                            3'b001, 3'b100, 3'b001};

    initial begin
        logic [2:0] exp;
        reset = 1'b1;
        in0   = 8'd0;
        in1   = 8'd0;

        // Reset clears registered flags before any clock edge.
        #1;
        chk("q_reset_noedge", {lt_q, eq_q, gt_q}, 3'b000);

        // Directed combinational vectors, reset still high.
        for (int i = 0; i < NV; i++) begin
            in0 = va[i];
            in1 = vb[i];
            #8;
            chk($sformatf("dir%0d_%0d_%0d", i, va[i], vb[i]), {lt, eq, gt}, ve[i]);
            chk("dir_onehot", {2'b00, $countones({lt, eq, gt}) == 1}, 3'b001);
        end
        chk("q_held_in_reset", {lt_q, eq_q, gt_q}, 3'b000);

        // Release reset and capture (3,9).
        @(negedge clk);
        reset = 1'b0;
        in0 = 8'd3;
        in1 = 8'd9;
        @(posedge clk);
        #1;
        chk("q_3_9", {lt_q, eq_q, gt_q}, 3'b100);

        @(negedge clk);
        in0 = 8'd9;
        in1 = 8'd3;
        @(posedge clk);
        #1;
        chk("q_9_3", {lt_q, eq_q, gt_q}, 3'b001);

        @(negedge clk);
        in0 = 8'd77;
        in1 = 8'd77;
        @(posedge clk);
        #1;
        chk("q_77_77", {lt_q, eq_q, gt_q}, 3'b010);

        // Mid-run asynchronous reset, away from the rising edge.
        @(negedge clk);
        in0 = 8'd200;
        in1 = 8'd10;
        #1;
        reset = 1'b1;
        #1;
        chk("q_async_reset", {lt_q, eq_q, gt_q}, 3'b000);
        chk("comb_in_reset", {lt, eq, gt}, 3'b001);
        @(posedge clk);
        #1;
        chk("q_reset_hold", {lt_q, eq_q, gt_q}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("q_after_release", {lt_q, eq_q, gt_q}, 3'b001);

        // Random pairs against a golden unsigned compare.
        for (int i = 0; i < 24; i++) begin
            in0 = 8'($urandom_range(0, 255));
            in1 = 8'($urandom_range(0, 255));
            #8;
            exp = {in0 < in1, in0 == in1, in0 > in1};
            chk($sformatf("rnd%0d_%0d_%0d", i, in0, in1), {lt, eq, gt}, exp);
            chk("rnd_onehot", {2'b00, $countones({lt, eq, gt}) == 1}, 3'b001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
